// File: rtl/serial_subtractor_pkg.sv
// Shared arithmetic definitions for the serial subtractor: state encoding and default width.
package serial_subtractor_pkg;

   localparam int unsigned DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Single-bit full subtractor cell: d = x - y - bin, with borrow-out.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor, LSB first, one bit per clock with a start/done handshake.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   state_t             state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   res;
   logic [CNT_W-1:0]   cnt;
   logic               bin;
   logic               d_c;
   logic               bout_c;
   logic [WIDTH-1:0]   res_next_c;
`ifdef SERIAL_SUB_OVF_EN
   logic               a_msb;
   logic               b_msb;
`endif

   full_subtractor u_fs (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (bin),
      .d    (d_c),
      .bout (bout_c)
   );

   // New bit enters from the MSB side; after the last bit this is the full result.
   assign res_next_c = {d_c, res};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= ST_IDLE;
         a_sr   <= '0;
         b_sr   <= '0;
         res    <= '0;
         cnt    <= '0;
         bin    <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         diff   <= '0;
         borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
         a_msb  <= 1'b0;
         b_msb  <= 1'b0;
         ovf    <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  a_sr  <= a;
                  b_sr  <= b;
                  cnt   <= '0;
                  bin   <= 1'b0;
                  busy  <= 1'b1;
                  state <= ST_SHIFT;
`ifdef SERIAL_SUB_OVF_EN
                  a_msb <= a[WIDTH-1];
                  b_msb <= b[WIDTH-1];
`endif
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            ST_SHIFT: begin
               a_sr <= {1'b0, a_sr[WIDTH-1:1]};
               b_sr <= {1'b0, b_sr[WIDTH-1:1]};
               res  <= res_next_c[WIDTH-1:1];
               bin  <= bout_c;
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  state  <= ST_DONE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  diff   <= res_next_c;
                  borrow <= bout_c;
`ifdef SERIAL_SUB_OVF_EN
                  ovf    <= (a_msb ^ b_msb) & (a_msb ^ d_c);
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector bench for serial_subtractor (8-bit); ovf checks active with SERIAL_SUB_OVF_EN.
module tb_serial_subtractor;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         borrow;
`ifdef SERIAL_SUB_OVF_EN
   logic         ovf;
`endif

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .diff   (diff),
      .borrow (borrow)
`ifdef SERIAL_SUB_OVF_EN
      ,
      .ovf    (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Waits (bounded) at falling edges until done; counts busy samples on the way.
   task automatic wait_done(output int cyc, output int busy_cyc);
      cyc      = 0;
      busy_cyc = 0;
      while (done !== 1'b1 && cyc < 40) begin
         if (busy === 1'b1) busy_cyc++;
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic launch(input logic [W-1:0] av, input logic [W-1:0] bv);
      @(negedge clk);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] exp_d, input logic exp_b, input logic exp_o);
      int cyc, bc;
      launch(av, bv);
      wait_done(cyc, bc);
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_cycles"}, 32'(bc), 32'd8);
      check({tag, "_diff"}, 32'(diff), 32'(exp_d));
      check({tag, "_borrow"}, 32'(borrow), 32'(exp_b));
`ifdef SERIAL_SUB_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
`else
      if (exp_o !== 1'bx) begin end
`endif
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int cyc, bc, seen;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_diff", 32'(diff), 32'd0);
      check("rst_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("rst_ovf", 32'(ovf), 32'd0);
`endif
      rst  = 1'b0;
      seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("idle_no_done", 32'(seen), 32'd0);

      // Basic vectors
      do_op("v5a_23", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0);
      do_op("v10_20", 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0);
      do_op("v00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
      do_op("v80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
      do_op("v05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);

      // start during SHIFT is ignored; diff holds previous result meanwhile
      launch(8'h33, 8'h11);
      repeat (2) @(negedge clk);
      a     = 8'hFF;
      b     = 8'hFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("ign_hold_diff", 32'(diff), 32'h02);
      check("ign_busy", 32'(busy), 32'd1);
      wait_done(cyc, bc);
      check("ign_done", 32'(done), 32'd1);
      check("ign_diff", 32'(diff), 32'h22);
      check("ign_borrow", 32'(borrow), 32'd0);
      @(negedge clk);

      // Back-to-back: start held through DONE
      launch(8'h44, 8'h04);
      wait_done(cyc, bc);
      check("b2b_first_done", 32'(done), 32'd1);
      check("b2b_first_diff", 32'(diff), 32'h40);
      a     = 8'hFF;
      b     = 8'h01;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("b2b_busy", 32'(busy), 32'd1);
      check("b2b_hold_diff", 32'(diff), 32'h40);
      wait_done(cyc, bc);
      check("b2b_latency", 32'(cyc), 32'd8);
      check("b2b_done", 32'(done), 32'd1);
      check("b2b_diff", 32'(diff), 32'hFE);
      check("b2b_borrow", 32'(borrow), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
      check("b2b_ovf", 32'(ovf), 32'd0);
`endif
      @(negedge clk);

      // Reset in the middle of an operation
      launch(8'h77, 8'h11);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_diff", 32'(diff), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      check("mid_rst_no_done", 32'(seen), 32'd0);
      do_op("v09_04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
